// File: rtl/mips_mc_pkg.sv
// Shared opcodes, state codes and control encodings for the multicycle MIPS.
// Imported by the control FSM, its interface, the ALU decoder and the datapath.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       branch;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Last state of every legal instruction; leaving it retires the instr.
    function automatic logic is_retire(state_t s);
        return (s == S_MEMWB)  || (s == S_MEMWR)  ||
               (s == S_ALUWB)  || (s == S_ADDIWB) ||
               (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle FSM and the datapath/IR.
// master = control FSM (drives controls), slave = datapath side.
interface mc_control_fsm_if;

    logic [5:0] op;
    logic       zero;
    logic       stall;
    logic       pcen;
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;

    modport master (
        input  op, zero, stall,
        output pcen, pcwrite, memwrite, irwrite, regwrite,
        output alusrca, branch, iord, memtoreg, regdst,
        output alusrcb, pcsrc, aluop, illegal_op
    );

    modport slave (
        output op, zero, stall,
        input  pcen, pcwrite, memwrite, irwrite, regwrite,
        input  alusrca, branch, iord, memtoreg, regdst,
        input  alusrcb, pcsrc, aluop, illegal_op
    );

endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: op/zero/stall in, per-cycle controls out.
// Ports: clk, reset (sync, active-low), bus (controls), state, instr_count.
module mc_control_fsm
    import mips_mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           st_q;
    state_t           st_d;
    state_t           view;
    logic             dec_bad;
    logic             we_ok;
    ctrl_t            c;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= S_FETCH;
            cnt_q <= '0;
        end else if (!bus.stall) begin
            st_q <= st_d;
            if (is_retire(st_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        st_d    = S_FETCH;
        dec_bad = 1'b0;
        case (st_q)
            S_FETCH:   st_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (bus.op == OP_LW) || (bus.op == OP_SW): st_d = S_MEMADR;
                    (bus.op == OP_RTYPE): st_d = S_EXECUTE;
                    (bus.op == OP_BEQ):   st_d = S_BRANCH;
                    (bus.op == OP_ADDI):  st_d = S_ADDIEX;
                    (bus.op == OP_J):     st_d = S_JUMP;
                    default:              dec_bad = 1'b1;
                endcase
            end
            S_MEMADR:  st_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   st_d = S_MEMWB;
            S_EXECUTE: st_d = S_ALUWB;
            S_ADDIEX:  st_d = S_ADDIWB;
            default:   st_d = S_FETCH;
        endcase
    end

    // While in reset the outputs present FETCH regardless of the register.
    assign view  = reset ? st_q : S_FETCH;
    assign we_ok = reset & ~bus.stall;

    always_comb begin
        c = '0;
        case (view)
            S_FETCH: begin
                c.alusrcb = ALUSRCB_FOUR;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            S_DECODE:  c.alusrcb = ALUSRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
            end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            default:   c = '0;
        endcase
        c.pcwrite  = c.pcwrite  & we_ok;
        c.memwrite = c.memwrite & we_ok;
        c.irwrite  = c.irwrite  & we_ok;
        c.regwrite = c.regwrite & we_ok;
        c.branch   = c.branch   & we_ok;
    end

    assign bus.pcen       = c.pcwrite | (c.branch & bus.zero);
    assign bus.pcwrite    = c.pcwrite;
    assign bus.memwrite   = c.memwrite;
    assign bus.irwrite    = c.irwrite;
    assign bus.regwrite   = c.regwrite;
    assign bus.alusrca    = c.alusrca;
    assign bus.branch     = c.branch;
    assign bus.iord       = c.iord;
    assign bus.memtoreg   = c.memtoreg;
    assign bus.regdst     = c.regdst;
    assign bus.alusrcb    = c.alusrcb;
    assign bus.pcsrc      = c.pcsrc;
    assign bus.aluop      = c.aluop;
    assign bus.illegal_op = we_ok & dec_bad;
    assign state          = STATE_W'(view);
    assign instr_count    = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table plus random
// stimulus against an instruction-path reference model.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       branch;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic       stl;
        logic [5:0] op;
        logic       zr;
        int         st;
        logic       pcen;
        logic       rw;
        logic       mw;
        logic       ill;
        logic       rd;
        logic [1:0] ps;
        int         cnt;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] AD = 6'b001000;
    localparam logic [5:0] JJ = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  state;
    logic [31:0] instr_count;
    int          tests = 0;
    int          fails = 0;
    vec_t        vq[$];

    mc_control_fsm_if bus();

    mc_control_fsm #(.CNT_W(32), .STATE_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Control values each state asserts when enabled.
    function automatic ctl_t mk(int s);
        ctl_t t = '0;
        case (s)
            0: begin t.alusrcb = 2'b01; t.irwrite = 1; t.pcwrite = 1; end
            1: t.alusrcb = 2'b11;
            2, 9: begin t.alusrca = 1; t.alusrcb = 2'b10; end
            3: t.iord = 1;
            4: begin t.memtoreg = 1; t.regwrite = 1; end
            5: begin t.iord = 1; t.memwrite = 1; end
            6: begin t.alusrca = 1; t.aluop = 2'b10; end
            7: begin t.regdst = 1; t.regwrite = 1; end
            8: begin
                t.alusrca = 1; t.aluop = 2'b01;
                t.pcsrc = 2'b01; t.branch = 1;
            end
            10: t.regwrite = 1;
            11: begin t.pcsrc = 2'b10; t.pcwrite = 1; end
            default: t = '0;
        endcase
        return t;
    endfunction

    // State sequence each instruction walks through.
    function automatic int path_len(logic [5:0] o);
        case (o)
            LW: return 5;
            SW, RT, AD: return 4;
            BQ, JJ: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int path_st(logic [5:0] o, int i);
        int p[$];
        case (o)
            LW: p = {0, 1, 2, 3, 4};
            SW: p = {0, 1, 2, 5};
            RT: p = {0, 1, 6, 7};
            AD: p = {0, 1, 9, 10};
            BQ: p = {0, 1, 8};
            JJ: p = {0, 1, 11};
            default: p = {0, 1};
        endcase
        return p[i];
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t t;
        t.pcwrite  = bus.pcwrite;
        t.memwrite = bus.memwrite;
        t.irwrite  = bus.irwrite;
        t.regwrite = bus.regwrite;
        t.branch   = bus.branch;
        t.alusrca  = bus.alusrca;
        t.iord     = bus.iord;
        t.memtoreg = bus.memtoreg;
        t.regdst   = bus.regdst;
        t.alusrcb  = bus.alusrcb;
        t.pcsrc    = bus.pcsrc;
        t.aluop    = bus.aluop;
        return t;
    endfunction

    function automatic void add(logic r, logic s, logic [5:0] o,
                                logic z, int st, logic pc, logic rw,
                                logic mw, logic il, logic rd,
                                logic [1:0] ps, int cn);
        vec_t v;
        v.rst = r; v.stl = s; v.op = o; v.zr = z; v.st = st;
        v.pcen = pc; v.rw = rw; v.mw = mw; v.ill = il;
        v.rd = rd; v.ps = ps; v.cnt = cn;
        vq.push_back(v);
    endfunction

    task automatic drive(logic r, logic s, logic [5:0] o, logic z);
        @(negedge clk);
        reset     = r;
        bus.stall = s;
        bus.op    = o;
        bus.zero  = z;
        #2;
    endtask

    initial begin
        int   idx;
        logic [31:0] mcnt;
        bus.op = LW; bus.zero = 0; bus.stall = 0;

        // reset, LW
        add(0,0,LW,0, 0,0,0,0,0,0,0,-1);
        add(0,0,LW,0, 0,0,0,0,0,0,0,0);
        add(0,0,LW,0, 0,0,0,0,0,0,0,0);
        add(1,0,LW,0, 0,1,0,0,0,0,0,0);
        add(1,0,LW,0, 1,0,0,0,0,0,0,0);
        add(1,0,LW,0, 2,0,0,0,0,0,0,0);
        add(1,0,LW,0, 3,0,0,0,0,0,0,0);
        add(1,0,LW,0, 4,0,1,0,0,0,0,0);
        // BEQ taken / not taken
        add(1,0,BQ,1, 0,1,0,0,0,0,0,1);
        add(1,0,BQ,1, 1,0,0,0,0,0,0,1);
        add(1,0,BQ,1, 8,1,0,0,0,0,1,1);
        add(1,0,BQ,0, 0,1,0,0,0,0,0,2);
        add(1,0,BQ,0, 1,0,0,0,0,0,0,2);
        add(1,0,BQ,0, 8,0,0,0,0,0,1,2);
        // SW with stall in MEMWR
        add(1,0,SW,0, 0,1,0,0,0,0,0,3);
        add(1,0,SW,0, 1,0,0,0,0,0,0,3);
        add(1,0,SW,0, 2,0,0,0,0,0,0,3);
        add(1,1,SW,0, 5,0,0,0,0,0,0,3);
        add(1,1,SW,0, 5,0,0,0,0,0,0,3);
        add(1,0,SW,0, 5,0,0,1,0,0,0,3);
        // illegal, first DECODE cycle stalled
        add(1,0,BAD,0, 0,1,0,0,0,0,0,4);
        add(1,1,BAD,0, 1,0,0,0,0,0,0,4);
        add(1,0,BAD,0, 1,0,0,0,1,0,0,4);
        // RTYPE, ADDI, J
        add(1,0,RT,0, 0,1,0,0,0,0,0,4);
        add(1,0,RT,0, 1,0,0,0,0,0,0,4);
        add(1,0,RT,0, 6,0,0,0,0,0,0,4);
        add(1,0,RT,0, 7,0,1,0,0,1,0,4);
        add(1,0,AD,0, 0,1,0,0,0,0,0,5);
        add(1,0,AD,0, 1,0,0,0,0,0,0,5);
        add(1,0,AD,0, 9,0,0,0,0,0,0,5);
        add(1,0,AD,0,10,0,1,0,0,0,0,5);
        add(1,0,JJ,0, 0,1,0,0,0,0,0,6);
        add(1,0,JJ,0, 1,0,0,0,0,0,0,6);
        add(1,0,JJ,0,11,1,0,0,0,0,2,6);
        // LW abandoned by reset in MEMRD
        add(1,0,LW,0, 0,1,0,0,0,0,0,7);
        add(1,0,LW,0, 1,0,0,0,0,0,0,7);
        add(1,0,LW,0, 2,0,0,0,0,0,0,7);
        add(0,0,LW,0, 0,0,0,0,0,0,0,7);
        add(1,0,LW,0, 0,1,0,0,0,0,0,0);
        add(1,0,LW,0, 1,0,0,0,0,0,0,0);

        foreach (vq[i]) begin
            vec_t v;
            logic ok;
            v = vq[i];
            drive(v.rst, v.stl, v.op, v.zr);
            ok = (int'(state) == v.st) && (bus.pcen === v.pcen) &&
                 (bus.regwrite === v.rw) && (bus.memwrite === v.mw) &&
                 (bus.illegal_op === v.ill) && (bus.regdst === v.rd) &&
                 (bus.pcsrc === v.ps) &&
                 (v.cnt < 0 || instr_count === 32'(v.cnt));
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL vec%0d: got st=%0d pcen=%b rw=%b mw=%b ill=%b rd=%b ps=%b cnt=%0d want st=%0d pcen=%b rw=%b mw=%b ill=%b rd=%b ps=%b cnt=%0d",
                         i, state, bus.pcen, bus.regwrite, bus.memwrite,
                         bus.illegal_op, bus.regdst, bus.pcsrc, instr_count,
                         v.st, v.pcen, v.rw, v.mw, v.ill, v.rd, v.ps, v.cnt);
            end
            @(posedge clk);
        end

        // Random run against the path model; first cycle is a reset.
        idx  = 0;
        mcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            logic       r, s, z, e_pcen, e_ill;
            logic [5:0] o;
            int         e_st, len;
            ctl_t       e, d;
            r = (n == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            s = ($urandom_range(0, 3) == 0);
            z = 1'($urandom);
            o = bus.op;
            if (idx == 0) begin
                case ($urandom_range(0, 7))
                    0: o = LW;  1: o = SW;  2: o = RT;
                    3: o = BQ;  4: o = AD;  5: o = JJ;
                    default: o = 6'($urandom);
                endcase
            end
            drive(r, s, o, z);
            len  = path_len(o);
            e_st = r ? path_st(o, idx) : 0;
            e    = mk(e_st);
            if (!r || s) begin
                e.pcwrite = 0; e.memwrite = 0; e.irwrite = 0;
                e.regwrite = 0; e.branch = 0;
            end
            e_pcen = e.pcwrite | (e.branch & z);
            e_ill  = r && !s && idx == 1 && len == 2;
            d = dut_ctl();
            tests++;
            if (d !== e || bus.pcen !== e_pcen ||
                bus.illegal_op !== e_ill || int'(state) != e_st ||
                (n > 0 && instr_count !== mcnt)) begin
                fails++;
                $display("FAIL rand%0d op=%b: got st=%0d ctl=%h pcen=%b ill=%b cnt=%0d want st=%0d ctl=%h pcen=%b ill=%b cnt=%0d",
                         n, o, state, d, bus.pcen, bus.illegal_op,
                         instr_count, e_st, e, e_pcen, e_ill, mcnt);
            end
            @(posedge clk);
            if (!r) begin
                idx  = 0;
                mcnt = 0;
            end else if (!s) begin
                idx++;
                if (idx == len) begin
                    idx = 0;
                    if (len > 2) mcnt++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle MIPS control state machine. It sits between the instruction register and the datapath, consuming the 6-bit opcode and producing per-cycle datapath controls (write enables, mux selects, ALU op class). The ALU function decoder sits beside it and consumes its aluop. It also forms pcen from branch/zero and reports retired-instruction count and illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter
STATE_W, 4, width of state encoding (12 states used)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low (0 = reset)
op  in  6  opcode from instruction register (instr[31:26])
zero  in  1  ALU zero flag
stall  in  1  memory not ready; hold state this cycle
pcen  out  1  PC enable = pcwrite | (branch & zero)
pcwrite  out  1  unconditional PC write
memwrite  out  1  memory write enable
irwrite  out  1  instruction register write enable
regwrite  out  1  register file write enable
alusrca  out  1  0 = PC, 1 = register A
branch  out  1  conditional-branch cycle
iord  out  1  memory address: 0 = PC, 1 = ALUOut
memtoreg  out  1  write-back data: 0 = ALUOut, 1 = Data
regdst  out  1  destination: 0 = rt, 1 = rd
alusrcb  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = PCJump
aluop  out  2  00 = add, 01 = subtract, 10 = use funct
state  out  STATE_W  current state, for debug
illegal_op  out  1  one-cycle pulse on unsupported opcode
instr_count  out  CNT_W  retired instructions

Behaviour:
- States: FETCH(0) DECODE(1) MEMADR(2) MEMRD(3) MEMWB(4) MEMWR(5) EXECUTE(6) ALUWB(7) BRANCH(8) ADDIEX(9) ADDIWB(10) JUMP(11). Codes 12-15 are unreachable and go to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 100011 (LW) or 101011 (SW) -> MEMADR.
    - 000000 (RTYPE) -> EXECUTE.
    - 000100 (BEQ) -> BRANCH.
    - 001000 (ADDI) -> ADDIEX.
    - 000010 (J) -> JUMP.
    - Any other op -> FETCH, with illegal_op=1 for that DECODE cycle.
  - MEMADR -> MEMRD for LW, MEMWR for SW. op is sampled in MEMADR and must be held stable by the IR.
  - MEMRD->MEMWB, EXECUTE->ALUWB, ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Cycle counts: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Moore outputs. Any signal not listed for a state is 0.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regdst=0, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Stall: while stall=1, state and counter hold. pcwrite, memwrite, irwrite, regwrite, branch and pcen are forced 0. Mux selects and aluop keep their state values. illegal_op is suppressed while stalled and fires on the unstalled DECODE cycle.
- Reset: on any rising edge with reset=0, state<=FETCH and instr_count<=0, including mid-instruction (the partial instruction is abandoned and not counted). While reset=0, all write enables, pcen and illegal_op are forced 0. Selects show FETCH values and state output reads 0.
- instr_count increments by 1 on each unstalled cycle in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP. Illegal ops are not counted. The counter wraps modulo 2^CNT_W.
- Simultaneous events: reset dominates stall, and stall dominates the transition.

Decomposition:
- Shared package mips_mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state enum with the codes above;
  - ALUSRCB_*, PCSRC_*, ALUOP_* encodings, which the ALU decoder and datapath also import.
- No sub-module. Next-state and output decode are two always_comb blocks plus one always_ff.

Test Plan:
- Hold reset=0 for 3 cycles with stall=0, then release and apply op=100011 (LW) -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4, instr_count=1.
- Apply op=000100 (BEQ) with zero=1 in BRANCH -> pcen=1, pcsrc=01, aluop=01. Repeat with zero=0 -> pcen=0. Both take 3 cycles.
- Apply op=101011 (SW) and raise stall for 2 cycles in MEMWR -> state holds at 5 with memwrite=0. memwrite=1 on the first unstalled cycle, then FETCH.
- Apply op=111111 -> illegal_op pulses in DECODE, next state 0, instr_count unchanged.
- Sequence RTYPE, ADDI, J -> regdst=1 in ALUWB, regdst=0 in ADDIWB, pcsrc=10 with pcwrite=1 in JUMP. instr_count advances by 3 over 11 cycles.
- Drive reset=0 during MEMRD of an LW -> next state 0, instr_count=0, no regwrite pulse.
